// File: rtl/fifo_arb_pkg.sv
// Shared state type, width constants and round-robin search helper
// used by the FIFO write-side arbiter.
package fifo_arb_pkg;

  localparam int MAX_REQ        = 8;
  localparam int PICK_W         = $clog2(MAX_REQ);
  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_FIFO_DEPTH = 8;
  localparam int ID_W           = $clog2(DEF_NUM_REQ);
  localparam int CRED_W         = $clog2(DEF_FIFO_DEPTH + 1);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic              found;
    logic [PICK_W-1:0] idx;
  } rr_pick_t;

  // First valid requester at or after ptr, wrapping within num_req entries.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                       input logic [PICK_W-1:0]  ptr,
                                       input int                 num_req);
    rr_pick_t          res;
    logic [PICK_W-1:0] cand;
    res = '0;
    for (int k = 0; k < MAX_REQ; k++) begin
      cand = PICK_W'((int'(ptr) + k) % num_req);
      if (!res.found && (k < num_req) && valid[cand]) begin
        res.found = 1'b1;
        res.idx   = cand;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/fifo_credit_ctr.sv
// Free-slot counter mirroring downstream FIFO occupancy; pops seen while
// the counter is already full are ignored and flagged in a sticky error.
module fifo_credit_ctr #(
  parameter int FIFO_DEPTH = 8,
  parameter int CW         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  output logic [CW-1:0] credits,
  output logic          err_credit
);

  localparam logic [CW-1:0] FULL_CRED = CW'(FIFO_DEPTH);

  logic [CW-1:0] credits_q, credits_d;
  logic          err_q, err_d;
  logic          at_full, pop_ok, push_ok;

  always_comb begin
    at_full   = (credits_q == FULL_CRED);
    pop_ok    = pop && !at_full;
    push_ok   = push && (credits_q != '0);
    credits_d = credits_q;
    if (push_ok && !pop_ok) begin
      credits_d = credits_q - 1'b1;
    end else if (pop_ok && !push_ok) begin
      credits_d = credits_q + 1'b1;
    end
    err_d = err_q || (pop && at_full);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credits_q <= FULL_CRED;
      err_q     <= 1'b0;
    end else begin
      credits_q <= credits_d;
      err_q     <= err_d;
    end
  end

  assign credits    = credits_q;
  assign err_credit = err_q;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-atomic, credit-gated arbiter in front of a FIFO write port.
// Optional lock watchdog with wdog_evt output is enabled by defining FIFO_ARB_WDOG_EN.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ     = DEF_NUM_REQ,
  parameter int DATA_WIDTH  = 8,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int WDOG_CYCLES = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ-1:0]               req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic                             fifo_full,
  input  logic                             fifo_pop,
  output logic                             fifo_we,
  output logic [DATA_WIDTH-1:0]            fifo_wdata,
  output logic [$clog2(NUM_REQ)-1:0]       fifo_wid,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  credits,
  output logic                             locked,
`ifdef FIFO_ARB_WDOG_EN
  output logic                             wdog_evt,
`endif
  output logic                             err_credit
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  if (NUM_REQ < 2 || NUM_REQ > MAX_REQ || WDOG_CYCLES < 1) begin : g_bad_cfg
    $error("fifo_wr_arbiter: unsupported parameter combination");
  end

  arb_state_e          state_q, state_d;
  logic [IW-1:0]       owner_q, owner_d;
  logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]       wid_q, wid_d;
  logic [IW-1:0]       grant_id;
  logic                we_q, we_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                can_push, grant_any, xfer, xfer_last;
  logic [MAX_REQ-1:0]  valid_ext;
  rr_pick_t            pick;

  function automatic logic [IW-1:0] next_id(input logic [IW-1:0] id);
    return (int'(id) == NUM_REQ - 1) ? '0 : id + 1'b1;
  endfunction

  // Same-cycle pops are deliberately not counted, so the FIFO can never overrun.
  assign can_push  = (credits != '0) && !fifo_full;
  assign valid_ext = MAX_REQ'(req_valid);
  assign pick      = rr_pick(valid_ext, PICK_W'(rr_ptr_q), NUM_REQ);

  always_comb begin
    req_ready = '0;
    grant_any = 1'b0;
    grant_id  = owner_q;
    if (state_q == LOCKED) begin
      grant_any = 1'b1;
    end else if (pick.found) begin
      grant_any = 1'b1;
      grant_id  = IW'(pick.idx);
    end
    if (rst && grant_any) begin
      req_ready[grant_id] = can_push;
    end
    xfer      = rst && grant_any && can_push && req_valid[grant_id];
    xfer_last = req_last[grant_id];
  end

`ifdef FIFO_ARB_WDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES + 1);
  logic [WD_W-1:0] wdog_cnt_q, wdog_cnt_d;
  logic            wdog_evt_q, wdog_evt_d;
`endif

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    we_d     = xfer;
    wdata_d  = wdata_q;
    wid_d    = wid_q;
    if (xfer) begin
      wdata_d = req_data[grant_id*DATA_WIDTH +: DATA_WIDTH];
      wid_d   = grant_id;
      if (!xfer_last) begin
        state_d = LOCKED;
        owner_d = grant_id;
      end else begin
        state_d  = IDLE;
        rr_ptr_d = next_id(grant_id);
      end
    end
`ifdef FIFO_ARB_WDOG_EN
    wdog_cnt_d = '0;
    wdog_evt_d = 1'b0;
    // Counts only idle owner cycles; a stalled-but-valid owner keeps its count.
    if (state_q == LOCKED && !xfer) begin
      if (!req_valid[owner_q]) begin
        if (int'(wdog_cnt_q) == WDOG_CYCLES - 1) begin
          state_d    = IDLE;
          rr_ptr_d   = next_id(owner_q);
          wdog_evt_d = 1'b1;
        end else begin
          wdog_cnt_d = wdog_cnt_q + 1'b1;
        end
      end else begin
        wdog_cnt_d = wdog_cnt_q;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      wid_q    <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      wid_q    <= wid_d;
    end
  end

`ifdef FIFO_ARB_WDOG_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdog_cnt_q <= '0;
      wdog_evt_q <= 1'b0;
    end else begin
      wdog_cnt_q <= wdog_cnt_d;
      wdog_evt_q <= wdog_evt_d;
    end
  end

  assign wdog_evt = wdog_evt_q;
`endif

  fifo_credit_ctr #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .CW         (CW)
  ) u_credit (
    .clk        (clk),
    .rst        (rst),
    .push       (xfer),
    .pop        (fifo_pop),
    .credits    (credits),
    .err_credit (err_credit)
  );

  assign fifo_we    = we_q;
  assign fifo_wdata = wdata_q;
  assign fifo_wid   = wid_q;
  assign locked     = (state_q == LOCKED);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: fixed vector table, directed
// corner sequences and randomized traffic against a cycle-level reference model.
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;
  import fifo_arb_pkg::*;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [N-1:0]      req_valid = '0;
  logic [N-1:0]      req_last = '0;
  logic [N*DW-1:0]   req_data = '0;
  logic [N-1:0]      req_ready;
  logic              fifo_full = 1'b0;
  logic              fifo_pop = 1'b0;
  logic              fifo_we;
  logic [DW-1:0]     fifo_wdata;
  logic [ID_W-1:0]   fifo_wid;
  logic [CRED_W-1:0] credits;
  logic              locked;
  logic              err_credit;
`ifdef FIFO_ARB_WDOG_EN
  logic              wdog_evt;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model state: plain integers, not the RTL encoding.
  int        m_cred, m_rr, m_owner, m_wid;
  bit        m_locked, m_we, m_err;
  logic [7:0] m_wdata;
  int        wr_log[$];

  typedef struct {
    logic [3:0]  v;
    logic [3:0]  l;
    logic [31:0] d;
    logic        f;
    logic        p;
    logic [3:0]  e_ready;
    logic        e_we;
    logic [7:0]  e_wdata;
    logic [1:0]  e_wid;
    logic [3:0]  e_cred;
    logic        e_lock;
  } vec_t;

  vec_t vecs[9];

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .NUM_REQ     (N),
    .DATA_WIDTH  (DW),
    .FIFO_DEPTH  (DEPTH),
    .WDOG_CYCLES (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_last   (req_last),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .fifo_full  (fifo_full),
    .fifo_pop   (fifo_pop),
    .fifo_we    (fifo_we),
    .fifo_wdata (fifo_wdata),
    .fifo_wid   (fifo_wid),
    .credits    (credits),
    .locked     (locked),
`ifdef FIFO_ARB_WDOG_EN
    .wdog_evt   (wdog_evt),
`endif
    .err_credit (err_credit)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] v, input logic [N-1:0] l,
                               input logic [N*DW-1:0] d, input logic f, input logic p);
    req_valid = v;
    req_last  = l;
    req_data  = d;
    fifo_full = f;
    fifo_pop  = p;
  endtask

  task automatic model_reset();
    m_cred = DEPTH; m_rr = 0; m_owner = 0; m_wid = 0;
    m_locked = 0; m_we = 0; m_err = 0; m_wdata = '0;
  endtask

  function automatic logic [N-1:0] model_ready();
    logic [N-1:0] r;
    bit can;
    r = '0;
    can = (m_cred > 0) && !fifo_full;
    if (!rst) return r;
    if (m_locked) begin
      r[m_owner] = can;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (req_valid[(m_rr + k) % N]) begin
          r[(m_rr + k) % N] = can;
          break;
        end
      end
    end
    return r;
  endfunction

  task automatic model_advance();
    logic [N-1:0] r;
    int xi;
    bit pop_ok;
    r = model_ready();
    xi = -1;
    for (int i = 0; i < N; i++) if (req_valid[i] && r[i]) xi = i;
    pop_ok = fifo_pop && (m_cred != DEPTH);
    if (fifo_pop && m_cred == DEPTH) m_err = 1;
    m_we = (xi >= 0);
    if (xi >= 0) begin
      m_wdata = req_data[xi*DW +: DW];
      m_wid   = xi;
      m_cred--;
      if (req_last[xi]) begin
        m_locked = 0;
        m_rr     = (xi + 1) % N;
      end else begin
        m_locked = 1;
        m_owner  = xi;
      end
    end
    if (pop_ok) m_cred++;
  endtask

  task automatic compare_model();
    checkOutput("ready", 32'(req_ready), 32'(model_ready()));
    checkOutput("we", 32'(fifo_we), 32'(m_we));
    checkOutput("wdata", 32'(fifo_wdata), 32'(m_wdata));
    checkOutput("wid", 32'(fifo_wid), m_wid);
    checkOutput("credits", 32'(credits), m_cred);
    checkOutput("locked", 32'(locked), 32'(m_locked));
    checkOutput("err_credit", 32'(err_credit), 32'(m_err));
  endtask

  // One clock: drive, sample at negedge, advance model, return at posedge+1.
  task automatic step(input logic [N-1:0] v, input logic [N-1:0] l,
                      input logic [N*DW-1:0] d, input logic f, input logic p);
    applyStimulus(v, l, d, f, p);
    @(negedge clk);
    compare_model();
    if (fifo_we) wr_log.push_back(int'(fifo_wid));
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    applyStimulus('1, '1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    repeat (3) begin
      @(negedge clk);
      checkOutput("rst_ready", 32'(req_ready), 32'h0);
      checkOutput("rst_we", 32'(fifo_we), 32'h0);
      checkOutput("rst_credits", 32'(credits), 32'd8);
      checkOutput("rst_locked", 32'(locked), 32'h0);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    wr_log.delete();
    applyStimulus('0, '0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    vecs[0] = '{4'b1111, 4'b1111, 32'h03020100, 1'b0, 1'b0, 4'b0001, 1'b0, 8'h00, 2'd0, 4'd8, 1'b0};
    vecs[1] = '{4'b1111, 4'b1111, 32'h13121110, 1'b0, 1'b1, 4'b0010, 1'b1, 8'h00, 2'd0, 4'd7, 1'b0};
    vecs[2] = '{4'b1111, 4'b1111, 32'h23222120, 1'b0, 1'b1, 4'b0100, 1'b1, 8'h11, 2'd1, 4'd7, 1'b0};
    vecs[3] = '{4'b0101, 4'b1111, 32'h33323130, 1'b0, 1'b0, 4'b0001, 1'b1, 8'h22, 2'd2, 4'd7, 1'b0};
    vecs[4] = '{4'b1000, 4'b0000, 32'h43424140, 1'b0, 1'b0, 4'b1000, 1'b1, 8'h30, 2'd0, 4'd6, 1'b0};
    vecs[5] = '{4'b0011, 4'b0000, 32'h53525150, 1'b0, 1'b0, 4'b1000, 1'b1, 8'h43, 2'd3, 4'd5, 1'b1};
    vecs[6] = '{4'b1001, 4'b1000, 32'h63626160, 1'b0, 1'b1, 4'b1000, 1'b0, 8'h43, 2'd3, 4'd5, 1'b1};
    vecs[7] = '{4'b0011, 4'b0011, 32'h73727170, 1'b1, 1'b0, 4'b0000, 1'b1, 8'h63, 2'd3, 4'd5, 1'b0};
    vecs[8] = '{4'b0010, 4'b0010, 32'h83828180, 1'b0, 1'b0, 4'b0010, 1'b0, 8'h63, 2'd3, 4'd5, 1'b0};

    // Vector table from reset: rotation, lock hold, full guard.
    do_reset();
    for (int n = 0; n < 9; n++) begin
      applyStimulus(vecs[n].v, vecs[n].l, vecs[n].d, vecs[n].f, vecs[n].p);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_ready", n), 32'(req_ready), 32'(vecs[n].e_ready));
      checkOutput($sformatf("vec%0d_we", n), 32'(fifo_we), 32'(vecs[n].e_we));
      checkOutput($sformatf("vec%0d_wdata", n), 32'(fifo_wdata), 32'(vecs[n].e_wdata));
      checkOutput($sformatf("vec%0d_wid", n), 32'(fifo_wid), 32'(vecs[n].e_wid));
      checkOutput($sformatf("vec%0d_credits", n), 32'(credits), 32'(vecs[n].e_cred));
      checkOutput($sformatf("vec%0d_locked", n), 32'(locked), 32'(vecs[n].e_lock));
      model_advance();
      @(posedge clk);
      #1;
    end

    // Fairness: all valid, single beats, pop every cycle.
    do_reset();
    repeat (10) step(4'b1111, 4'b1111, $urandom, 1'b0, 1'b1);
    checkOutput("fair_count", wr_log.size(), 9);
    for (int i = 0; i < wr_log.size(); i++) checkOutput($sformatf("fair_wid%0d", i), wr_log[i], i % N);

    // Atomicity: req0 three-beat packet while req1 waits.
    do_reset();
    step(4'b0011, 4'b0010, 32'h0000_00A1, 1'b0, 1'b0);
    checkOutput("atom_lock1", 32'(locked), 32'h1);
    step(4'b0011, 4'b0010, 32'h0000_00A2, 1'b0, 1'b0);
    checkOutput("atom_lock2", 32'(locked), 32'h1);
    step(4'b0011, 4'b0011, 32'h0000_00A3, 1'b0, 1'b0);
    checkOutput("atom_lock3", 32'(locked), 32'h0);
    step(4'b0010, 4'b0010, 32'h0000_B100, 1'b0, 1'b0);
    repeat (2) step(4'b0000, 4'b0000, '0, 1'b0, 1'b0);
    checkOutput("atom_count", wr_log.size(), 4);
    if (wr_log.size() == 4) begin
      checkOutput("atom_w0", wr_log[0], 0);
      checkOutput("atom_w1", wr_log[1], 0);
      checkOutput("atom_w2", wr_log[2], 0);
      checkOutput("atom_w3", wr_log[3], 1);
    end

    // Credit stall: req2 streams with no pops.
    do_reset();
    repeat (12) step(4'b0100, 4'b0100, $urandom, 1'b0, 1'b0);
    checkOutput("stall_writes", wr_log.size(), 8);
    checkOutput("stall_credits", 32'(credits), 32'd0);
    checkOutput("stall_ready", 32'(req_ready), 32'h0);
    step(4'b0100, 4'b0100, $urandom, 1'b0, 1'b1);
    checkOutput("stall_pop_credits", 32'(credits), 32'd1);
    repeat (4) step(4'b0100, 4'b0100, $urandom, 1'b0, 1'b0);
    checkOutput("stall_writes2", wr_log.size(), 9);
    checkOutput("stall_credits2", 32'(credits), 32'd0);

    // Simultaneous transfer and pop at credits=3, then pop at full credit.
    do_reset();
    repeat (5) step(4'b0001, 4'b0001, $urandom, 1'b0, 1'b0);
    checkOutput("sim_pre", 32'(credits), 32'd3);
    step(4'b0001, 4'b0001, $urandom, 1'b0, 1'b1);
    checkOutput("sim_post", 32'(credits), 32'd3);
    do_reset();
    step(4'b0000, 4'b0000, '0, 1'b0, 1'b1);
    checkOutput("ovf_credits", 32'(credits), 32'd8);
    checkOutput("ovf_err", 32'(err_credit), 32'h1);
    repeat (3) step(4'b0001, 4'b0001, $urandom, 1'b0, 1'b1);
    checkOutput("ovf_err_sticky", 32'(err_credit), 32'h1);

    // Asynchronous reset in the middle of a packet with a write pending.
    do_reset();
    step(4'b0001, 4'b0000, 32'h0000_0055, 1'b0, 1'b0);
    checkOutput("abort_we_pre", 32'(fifo_we), 32'h1);
    #2 rst = 1'b0;
    #1;
    checkOutput("abort_we", 32'(fifo_we), 32'h0);
    checkOutput("abort_locked", 32'(locked), 32'h0);
    checkOutput("abort_ready", 32'(req_ready), 32'h0);
    checkOutput("abort_credits", 32'(credits), 32'd8);

    // Abandoned lock: req1 stops mid-packet, req3 keeps asking.
    do_reset();
    step(4'b0010, 4'b0000, 32'h0000_7700, 1'b0, 1'b0);
    begin
      int seen3;
      seen3 = 0;
      repeat (40) begin
        step(4'b1000, 4'b1000, $urandom, 1'b0, 1'b0);
        if (req_ready[3]) seen3++;
      end
      checkOutput("nolock_req3_grants", seen3, 0);
    end

    // Randomized traffic against the reference model.
    do_reset();
    repeat (400) begin
      step(N'($urandom), N'($urandom), $urandom,
           ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin write-side controller that shares one sync FIFO write port (8x8 default) among NUM_REQ producers. Each producer offers a valid/ready stream with packet delimiting. The arbiter keeps multi-beat packets atomic and gates pushes with a credit counter that mirrors FIFO occupancy, so the FIFO is never overrun. It sits directly in front of the FIFO's we/w_data inputs and observes the consumer's successful pops.

Parameters:
NUM_REQ, 4, number of producers (2..8)
DATA_WIDTH, 8, FIFO data width
FIFO_DEPTH, 8, slots in the downstream FIFO; initial credit count
WDOG_CYCLES, 16, lock watchdog limit (used only with the optional feature)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
req_valid  in  NUM_REQ  per-producer beat valid
req_last  in  NUM_REQ  per-producer last beat of packet
req_data  in  NUM_REQ*DATA_WIDTH  producer i data at bits [i*DATA_WIDTH +: DATA_WIDTH]
req_ready  out  NUM_REQ  combinational one-hot-or-zero grant
fifo_full  in  1  downstream FIFO full flag (extra guard)
fifo_pop  in  1  one-cycle pulse per successful FIFO read (re && !empty)
fifo_we  out  1  registered FIFO write enable
fifo_wdata  out  DATA_WIDTH  registered FIFO write data
fifo_wid  out  $clog2(NUM_REQ)  registered source ID of the written beat
credits  out  $clog2(FIFO_DEPTH+1)  free slots as seen by the arbiter
locked  out  1  high in state LOCKED
err_credit  out  1  sticky: fifo_pop seen while credits == FIFO_DEPTH

Behaviour:
- Reset values: credits=FIFO_DEPTH, state=IDLE, rr_ptr=0, owner=0, fifo_we=0, fifo_wdata=0, fifo_wid=0, err_credit=0. req_ready=0 while rst=0.
- can_push = (credits != 0) && !fifo_full. A pop in the same cycle does not count toward can_push; the rule is conservative.
- IDLE state:
  - Search order is rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - The first i with req_valid[i] gets req_ready[i]=can_push. All other bits are 0.
- LOCKED state: only req_ready[owner]=can_push. Other requesters wait regardless of their valid.
- Transfer = req_valid[i] && req_ready[i]. At most one transfer per cycle.
- Write latency is 1 cycle. The edge after a transfer sets fifo_we=1, fifo_wdata=req_data[i], fifo_wid=i. With no transfer, fifo_we=0 and wdata/wid hold.
- Transitions (rr_ptr is updated whenever a packet completes):
  - IDLE, transfer with last=0 -> LOCKED, owner=i.
  - IDLE, transfer with last=1 -> stay IDLE, rr_ptr=(i+1) mod NUM_REQ.
  - LOCKED, owner transfer with last=1 -> IDLE, rr_ptr=(owner+1) mod NUM_REQ.
- Credits update: credits_next = credits - transfer + (fifo_pop && credits != FIFO_DEPTH). A simultaneous transfer and pop leaves credits unchanged. The count never wraps below 0 or above FIFO_DEPTH.
- Pop at credits==FIFO_DEPTH is ignored and sets err_credit until reset.
- Reset asserted mid-packet aborts the lock. Any pending registered write is dropped, with fifo_we=0 immediately (async).
- The producer must hold data/last stable while valid && !ready. The arbiter does not check this.

Optional Feature:
FIFO_ARB_WDOG_EN
- With the macro defined: in LOCKED, a counter increments each cycle that req_valid[owner]=0 and clears on any owner transfer. On reaching WDOG_CYCLES the arbiter:
  - forces state to IDLE;
  - sets rr_ptr=(owner+1) mod NUM_REQ;
  - pulses output wdog_evt for 1 cycle.
  The remainder of the owner's packet is then treated as new packets.
- Without the macro: no counter, no wdog_evt port, and LOCKED persists indefinitely.

Decomposition:
- Package fifo_arb_pkg holds:
  - typedef arb_state_e {IDLE, LOCKED};
  - function rr_pick(valid, ptr) returning index and found;
  - localparam widths ID_W and CRED_W.
- Sub-module fifo_credit_ctr holds the credit counter, saturation and err_credit logic. It is instantiated once.

Test Plan:
- Reset: hold rst=0 for 3 cycles with all req_valid=1 -> req_ready=0, fifo_we=0, credits=8, locked=0.
- Fairness: NUM_REQ=4, all valid with last=1 continuously, fifo_pop every cycle -> fifo_wid sequence 0,1,2,3,0,1,... and no gaps in fifo_we after the first cycle.
- Atomicity: req0 sends 3-beat packet (last on beat 3) while req1 is valid -> wids 0,0,0 then 1; locked=1 during beats 1-2.
- Credit stall: no pops, req2 streams 10 single beats -> exactly 8 fifo_we pulses, then req_ready=0 and credits=0. One fifo_pop then gives credits=1 and exactly one more write.
- Simultaneous: credits=3, transfer and fifo_pop in the same cycle -> credits stays 3. Pop with credits=8 -> credits=8, err_credit=1 sticky.
- Watchdog (FIFO_ARB_WDOG_EN, WDOG_CYCLES=16): req1 sends a non-last beat then drops valid, req3 valid -> wdog_evt pulses 16 cycles later, then req3 granted. Without the macro, req3 is never granted.
